alu_shift_mem_unit: RTL and testbench
=====================================

# alu_shift_mem_unit

Execute/memory-stage block of the 8-bit pipelined processor: an 8-bit ALU, an 8-bit barrel shifter and a 256×8 data memory addressed by the ALU result, with a result mux and registered carry (C) and zero (Z) flags. Operand, immediate and control inputs come from the decode stage. The selected result goes to register-file write-back. C and Z go to the controller for conditional branches.

## Interface
- No parameters; datapath width fixed at 8 bits, memory depth 256.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-low; clock clk
- op_a  in  8  ALU operand A and shifter data
- op_b  in  8  register operand B
- imm  in  8  immediate operand
- b_sel  in  1  ALU B source: 0 = op_b, 1 = imm
- alu_op  in  3  ALU operation code
- alu_use_carry  in  1  1 = ALU carry-in is the C flag; 0 = carry-in is 0
- sh_count  in  3  shift/rotate amount, 0–7
- sh_dir  in  1  0 = left, 1 = right
- sh_ro_bar  in  1  1 = logical shift (zero fill), 0 = rotate
- mem_write  in  1  data memory write enable
- mem_wdata  in  8  data memory write data
- result_sel  in  2  result source: 00 ALU, 01 shifter, 10 memory read, 11 constant 0x00
- select_c / select_z  in  1  next-flag source: 0 = ALU, 1 = shifter
- write_c / write_z  in  1  flag register load enables
- result  out  8  selected result, combinational
- alu_out  out  8  ALU result; also the memory address
- mem_rdata  out  8  memory read data at address alu_out, combinational
- C, Z  out  1  registered flags

## Operation
- ALU B operand = b_sel ? imm : op_b.
- ALU carry-in cin = alu_use_carry & C.
- ALU operations, 8-bit results, co = 0 unless stated:
  - 000 ADD: A+B+cin; co = bit 8 of the 9-bit sum.
  - 001 SUB: A−B−cin; co = borrow, i.e. 1 when A < B+cin unsigned.
  - 010 AND; 011 OR; 100 XOR; 101 MASK: A & ~B.
  - 110 PASSB: B; 111 PASSA: A.
- ALU zero = (alu result == 0x00).
- Shifter, count n = sh_count:
  - Logical left: data<<n. Carry = last bit shifted out, bit[8−n].
  - Logical right: data>>n. Carry = bit[n−1].
  - Rotate left: carry = result[0]. Rotate right: carry = result[7].
  - n = 0: result = data, carry = 0.
  - Shifter zero = (result == 0x00).
- Memory: 256×8. Asynchronous read of mem[alu_out]. Synchronous write of mem_wdata to mem[alu_out] when mem_write = 1 and reset = 1.
- Flags on the rising edge:
  - reset = 0: C = 0, Z = 0, all memory locations cleared to 0x00. Reset overrides mem_write and write_c/write_z.
  - Otherwise, when write_c = 1: C ← (select_c ? shifter carry : ALU co). When write_c = 0: C holds.
  - Z is loaded the same way, using write_z and select_z.
- All outputs other than C and Z are purely combinational from inputs, C and memory.

## Timing
- result, alu_out and mem_rdata are valid in the same cycle as the inputs; zero latency.
- Flag and memory updates take effect at the next rising edge. New values are visible immediately after that edge.
- Read and write to the same address in one cycle: mem_rdata shows old data until the edge, new data after.
- ADD or SUB with alu_use_carry uses the C value registered before the current edge. Flags written by instruction i are visible to instruction i+1 in the next cycle.
- Values after reset: C = 0, Z = 0, memory all 0x00. result then depends only on inputs.

## Test plan
- Reset: hold reset = 0 for one edge with mem_write = 1 and write_c = write_z = 1 → C = 0, Z = 0, and mem[0x15] reads 0x00 (write suppressed).
- ADD with flags:
  - 0xF0 + 0x20, write_c = write_z = 1 → result 0x10; after edge C = 1, Z = 0.
  - Then ADD 0x01 + 0x01 with alu_use_carry = 1 → 0x03.
  - With alu_use_carry = 0 → 0x02.
- SUB:
  - 0x05 − 0x05 → 0x00; after edge Z = 1, C = 0.
  - 0x03 − 0x05 → 0xFE; after edge C = 1, Z = 0.
- Logic ops:
  - AND 0xF0, 0x0F → 0x00 with Z = 1.
  - XOR 0xAA, 0xFF → 0x55.
  - MASK 0xFF, 0x0F → 0xF0.
  - imm path: b_sel = 1, imm = 0x01, ADD with op_a = 0x7F → 0x80.
- Shifter (select_c = select_z = 1):
  - Shift left 0x81 by 1 → 0x02, C = 1.
  - Shift right 0x80 by 7 → 0x01, C = 0.
  - Rotate right 0x01 by 1 → 0x80, C = 1.
  - Shift left 0x01 by 0 → 0x01, C = 0.
  - Shift left 0x80 by 1 → 0x00, Z = 1.
- Memory:
  - op_a = 0x10, imm = 0x05, b_sel = 1, ADD, mem_write = 1, mem_wdata = 0xA5 → before edge mem_rdata = 0x00. After edge, with result_sel = 10, result = 0xA5.
  - Writing 0x3C to 0xFF, then reading 0x00 → 0x00.

Source files
------------

// File: rtl/alu_shift_mem_unit_if.sv
// Bundle of decode-stage inputs and execute/memory-stage outputs for
// alu_shift_mem_unit.
//   Decode side (master) drives: op_a, op_b, imm, b_sel, alu_op, alu_use_carry,
//     sh_count, sh_dir, sh_ro_bar, mem_write, mem_wdata, result_sel,
//     select_c, select_z, write_c, write_z.
//   Unit side (slave) drives: result, alu_out, mem_rdata, C, Z.
interface alu_shift_mem_unit_if;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] imm;
    logic       b_sel;
    logic [2:0] alu_op;
    logic       alu_use_carry;
    logic [2:0] sh_count;
    logic       sh_dir;
    logic       sh_ro_bar;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [1:0] result_sel;
    logic       select_c;
    logic       select_z;
    logic       write_c;
    logic       write_z;
    logic [7:0] result;
    logic [7:0] alu_out;
    logic [7:0] mem_rdata;
    logic       C;
    logic       Z;

    modport master (
        output op_a, op_b, imm, b_sel, alu_op, alu_use_carry,
               sh_count, sh_dir, sh_ro_bar, mem_write, mem_wdata,
               result_sel, select_c, select_z, write_c, write_z,
        input  result, alu_out, mem_rdata, C, Z
    );

    modport slave (
        input  op_a, op_b, imm, b_sel, alu_op, alu_use_carry,
               sh_count, sh_dir, sh_ro_bar, mem_write, mem_wdata,
               result_sel, select_c, select_z, write_c, write_z,
        output result, alu_out, mem_rdata, C, Z
    );
endinterface

// File: rtl/alu_shift_mem_unit.sv
// Execute/memory stage of the 8-bit pipelined processor: 8-bit ALU, 8-bit
// barrel shifter, 256x8 data memory addressed by the ALU result, result mux,
// and registered carry (C) / zero (Z) flags.
//   clk    : clock, all state updates on rising edge
//   reset  : synchronous, active-low; clears C, Z and the whole memory
//   bus    : alu_shift_mem_unit_if.slave (operands/controls in; result,
//            alu_out, mem_rdata, C, Z out)
module alu_shift_mem_unit (
    input  logic                 clk,
    input  logic                 reset,
    alu_shift_mem_unit_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_MASK  = 3'b101,
        OP_PASSB = 3'b110,
        OP_PASSA = 3'b111
    } alu_op_e;

    alu_op_e     op;
    logic [7:0]  b_val;
    logic        cin;
    logic [8:0]  alu_full;
    logic [7:0]  alu_res;
    logic        alu_co;
    logic        alu_zero;

    logic [15:0] wide_l;
    logic [15:0] wide_r;
    logic [7:0]  sh_res;
    logic        sh_carry;
    logic        sh_zero;

    logic [7:0]  mem [256];
    logic        c_q;
    logic        z_q;

    assign op    = alu_op_e'(bus.alu_op);
    assign b_val = bus.b_sel ? bus.imm : bus.op_b;
    assign cin   = bus.alu_use_carry & c_q;

    // ALU; SUB's bit 8 of the 9-bit difference is the borrow
    always_comb begin
        alu_full = '0;
        alu_co   = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_full = {1'b0, bus.op_a} + {1'b0, b_val} + {8'b0, cin};
                alu_co   = alu_full[8];
            end
            OP_SUB: begin
                alu_full = {1'b0, bus.op_a} - {1'b0, b_val} - {8'b0, cin};
                alu_co   = alu_full[8];
            end
            OP_AND:   alu_full = {1'b0, bus.op_a & b_val};
            OP_OR:    alu_full = {1'b0, bus.op_a | b_val};
            OP_XOR:   alu_full = {1'b0, bus.op_a ^ b_val};
            OP_MASK:  alu_full = {1'b0, bus.op_a & ~b_val};
            OP_PASSB: alu_full = {1'b0, b_val};
            OP_PASSA: alu_full = {1'b0, bus.op_a};
            default:  alu_full = '0;
        endcase
    end

    assign alu_res  = alu_full[7:0];
    assign alu_zero = (alu_res == 8'h00);

    // Shift within a 16-bit window: the bits that fall off land in the other
    // byte, which gives both the rotate wrap-around and the last bit out.
    assign wide_l = {8'h00, bus.op_a} << bus.sh_count;
    assign wide_r = {bus.op_a, 8'h00} >> bus.sh_count;

    always_comb begin
        sh_res   = bus.op_a;
        sh_carry = 1'b0;
        if (bus.sh_count != 3'd0) begin
            if (!bus.sh_dir) begin
                sh_res   = bus.sh_ro_bar ? wide_l[7:0] : (wide_l[7:0] | wide_l[15:8]);
                sh_carry = bus.sh_ro_bar ? wide_l[8] : sh_res[0];
            end else begin
                sh_res   = bus.sh_ro_bar ? wide_r[15:8] : (wide_r[15:8] | wide_r[7:0]);
                sh_carry = bus.sh_ro_bar ? wide_r[7] : sh_res[7];
            end
        end
    end

    assign sh_zero = (sh_res == 8'h00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 256; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.mem_write) begin
            mem[alu_res] <= bus.mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            if (bus.write_c) c_q <= bus.select_c ? sh_carry : alu_co;
            if (bus.write_z) z_q <= bus.select_z ? sh_zero : alu_zero;
        end
    end

    assign bus.alu_out   = alu_res;
    assign bus.mem_rdata = mem[alu_res];
    assign bus.C         = c_q;
    assign bus.Z         = z_q;

    always_comb begin
        unique case (bus.result_sel)
            2'b00:   bus.result = alu_res;
            2'b01:   bus.result = sh_res;
            2'b10:   bus.result = bus.mem_rdata;
            default: bus.result = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_alu_shift_mem_unit.sv
// Self-checking bench for alu_shift_mem_unit: directed test-plan cases plus
// randomized instructions compared against an arithmetic reference model.
module tb_alu_shift_mem_unit;
    logic clk = 1'b0;
    logic reset;

    alu_shift_mem_unit_if bus ();

    alu_shift_mem_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    int m_mem [256];
    int m_c;
    int m_z;
    bit inited = 1'b0;

    logic [7:0] seen_result, seen_rdata, seen_alu;
    logic       seen_c, seen_z;

    task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void alu_ref(input int op, input int a, input int b, input int cin,
                                    output int res, output int co);
        int s;
        co = 0;
        case (op)
            0: begin s = a + b + cin; co = (s > 255) ? 1 : 0; end
            1: begin s = a - b - cin; co = (a < b + cin) ? 1 : 0; end
            2: s = a & b;
            3: s = a | b;
            4: s = a ^ b;
            5: s = a & (~b);
            6: s = b;
            default: s = a;
        endcase
        res = s & 255;
    endfunction

    function automatic void sh_ref(input int d, input int n, input int dir, input int logical,
                                   output int res, output int cy);
        res = d;
        cy  = 0;
        if (n == 0) return;
        if (logical != 0) begin
            if (dir == 0) begin
                res = (d << n) & 255;
                cy  = (d >> (8 - n)) & 1;
            end else begin
                res = d >> n;
                cy  = (d >> (n - 1)) & 1;
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                if (dir == 0) res = ((res << 1) | (res >> 7)) & 255;
                else          res = (res >> 1) | ((res & 1) << 7);
            end
            cy = (dir == 0) ? (res & 1) : ((res >> 7) & 1);
        end
    endfunction

    task automatic idle();
        reset             = 1'b1;
        bus.op_a          = '0;
        bus.op_b          = '0;
        bus.imm           = '0;
        bus.b_sel         = 1'b0;
        bus.alu_op        = '0;
        bus.alu_use_carry = 1'b0;
        bus.sh_count      = '0;
        bus.sh_dir        = 1'b0;
        bus.sh_ro_bar     = 1'b1;
        bus.mem_write     = 1'b0;
        bus.mem_wdata     = '0;
        bus.result_sel    = '0;
        bus.select_c      = 1'b0;
        bus.select_z      = 1'b0;
        bus.write_c       = 1'b0;
        bus.write_z       = 1'b0;
    endtask

    // Inputs are already driven (at the falling edge); check the combinational
    // outputs, clock once, check the flags and advance the model.
    task automatic step(string tag);
        int b, cin, ar, aco, sr, sco, rd, res;
        b   = bus.b_sel ? int'(bus.imm) : int'(bus.op_b);
        cin = bus.alu_use_carry ? m_c : 0;
        alu_ref(int'(bus.alu_op), int'(bus.op_a), b, cin, ar, aco);
        sh_ref(int'(bus.op_a), int'(bus.sh_count), int'(bus.sh_dir), int'(bus.sh_ro_bar), sr, sco);
        rd = m_mem[ar];
        case (bus.result_sel)
            2'b00:   res = ar;
            2'b01:   res = sr;
            2'b10:   res = rd;
            default: res = 0;
        endcase
        #1;
        seen_result = bus.result;
        seen_rdata  = bus.mem_rdata;
        seen_alu    = bus.alu_out;
        if (inited) begin
            check({tag, ".alu_out"},   bus.alu_out,   8'(ar));
            check({tag, ".mem_rdata"}, bus.mem_rdata, 8'(rd));
            check({tag, ".result"},    bus.result,    8'(res));
        end
        if (!reset) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_c = 0;
            m_z = 0;
            inited = 1'b1;
        end else begin
            if (bus.mem_write) m_mem[ar] = int'(bus.mem_wdata);
            if (bus.write_c) m_c = bus.select_c ? sco : aco;
            if (bus.write_z) m_z = bus.select_z ? ((sr == 0) ? 1 : 0) : ((ar == 0) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        seen_c = bus.C;
        seen_z = bus.Z;
        check({tag, ".C"}, {7'b0, bus.C}, 8'(m_c));
        check({tag, ".Z"}, {7'b0, bus.Z}, 8'(m_z));
        @(negedge clk);
    endtask

    task automatic alu_instr(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic use_c, input logic wr_flags);
        idle();
        bus.alu_op = op; bus.op_a = a; bus.op_b = b;
        bus.alu_use_carry = use_c;
        bus.write_c = wr_flags; bus.write_z = wr_flags;
    endtask

    task automatic sh_instr(input logic [7:0] d, input logic [2:0] n, input logic dir,
                            input logic logical);
        idle();
        bus.op_a = d; bus.sh_count = n; bus.sh_dir = dir; bus.sh_ro_bar = logical;
        bus.result_sel = 2'b01;
        bus.select_c = 1'b1; bus.select_z = 1'b1;
        bus.write_c = 1'b1; bus.write_z = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        step("reset0");

        // put data at 0x15 and set C, then reset with writes requested
        idle(); bus.op_a = 8'h15; bus.alu_op = 3'b111; bus.mem_write = 1'b1; bus.mem_wdata = 8'h77;
        bus.sh_count = 3'd4; bus.select_c = 1'b1; bus.write_c = 1'b1;
        step("prefill");
        check("prefill.C_set", {7'b0, seen_c}, 8'h01);
        idle(); reset = 1'b0; bus.op_a = 8'h15; bus.alu_op = 3'b111; bus.mem_write = 1'b1;
        bus.mem_wdata = 8'h99; bus.write_c = 1'b1; bus.write_z = 1'b1; bus.select_z = 1'b0;
        step("reset1");
        check("reset1.C0", {7'b0, seen_c}, 8'h00);
        check("reset1.Z0", {7'b0, seen_z}, 8'h00);
        idle(); bus.op_a = 8'h15; bus.alu_op = 3'b111; bus.result_sel = 2'b10;
        step("rd15");
        check("rd15.cleared", seen_result, 8'h00);

        alu_instr(3'b000, 8'hF0, 8'h20, 1'b0, 1'b1); step("add_f0_20");
        check("add_f0_20.res", seen_result, 8'h10);
        check("add_f0_20.C", {7'b0, seen_c}, 8'h01);
        alu_instr(3'b000, 8'h01, 8'h01, 1'b1, 1'b0); step("addc");
        check("addc.res", seen_result, 8'h03);
        alu_instr(3'b000, 8'h01, 8'h01, 1'b0, 1'b0); step("add_nc");
        check("add_nc.res", seen_result, 8'h02);
        alu_instr(3'b001, 8'h05, 8'h05, 1'b0, 1'b1); step("sub_eq");
        check("sub_eq.Z", {7'b0, seen_z}, 8'h01);
        alu_instr(3'b001, 8'h03, 8'h05, 1'b0, 1'b1); step("sub_neg");
        check("sub_neg.res", seen_result, 8'hFE);
        check("sub_neg.C", {7'b0, seen_c}, 8'h01);
        alu_instr(3'b010, 8'hF0, 8'h0F, 1'b0, 1'b1); step("and");
        check("and.Z", {7'b0, seen_z}, 8'h01);
        alu_instr(3'b100, 8'hAA, 8'hFF, 1'b0, 1'b0); step("xor");
        check("xor.res", seen_result, 8'h55);
        alu_instr(3'b101, 8'hFF, 8'h0F, 1'b0, 1'b0); step("mask");
        check("mask.res", seen_result, 8'hF0);
        alu_instr(3'b000, 8'h7F, 8'h00, 1'b0, 1'b0); bus.b_sel = 1'b1; bus.imm = 8'h01; step("imm");
        check("imm.res", seen_result, 8'h80);

        sh_instr(8'h81, 3'd1, 1'b0, 1'b1); step("shl1");
        check("shl1.res", seen_result, 8'h02);
        check("shl1.C", {7'b0, seen_c}, 8'h01);
        sh_instr(8'h80, 3'd7, 1'b1, 1'b1); step("shr7");
        check("shr7.res", seen_result, 8'h01);
        sh_instr(8'h01, 3'd1, 1'b1, 1'b0); step("ror1");
        check("ror1.res", seen_result, 8'h80);
        check("ror1.C", {7'b0, seen_c}, 8'h01);
        sh_instr(8'h01, 3'd0, 1'b0, 1'b1); step("shl0");
        check("shl0.C", {7'b0, seen_c}, 8'h00);
        sh_instr(8'h80, 3'd1, 1'b0, 1'b1); step("shl_zero");
        check("shl_zero.Z", {7'b0, seen_z}, 8'h01);

        alu_instr(3'b000, 8'h10, 8'h00, 1'b0, 1'b0);
        bus.b_sel = 1'b1; bus.imm = 8'h05; bus.mem_write = 1'b1; bus.mem_wdata = 8'hA5;
        bus.result_sel = 2'b10;
        step("memwr");
        check("memwr.old", seen_rdata, 8'h00);
        bus.mem_write = 1'b0; step("memrd");
        check("memrd.new", seen_result, 8'hA5);
        alu_instr(3'b111, 8'hFF, 8'h00, 1'b0, 1'b0); bus.mem_write = 1'b1; bus.mem_wdata = 8'h3C;
        step("memff");
        alu_instr(3'b111, 8'h00, 8'h00, 1'b0, 1'b0); bus.result_sel = 2'b10; step("mem00");
        check("mem00.res", seen_result, 8'h00);

        // random instruction stream; addresses narrowed half the time so reads hit writes
        for (int i = 0; i < 400; i++) begin
            idle();
            reset             = ($urandom_range(0, 59) != 0);
            bus.op_a          = 8'($urandom);
            if ($urandom_range(0, 1) == 0) bus.op_a = 8'($urandom_range(0, 15));
            bus.op_b          = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            bus.imm           = 8'($urandom);
            bus.b_sel         = 1'($urandom);
            bus.alu_op        = 3'($urandom);
            bus.alu_use_carry = 1'($urandom);
            bus.sh_count      = 3'($urandom);
            bus.sh_dir        = 1'($urandom);
            bus.sh_ro_bar     = 1'($urandom);
            bus.mem_write     = 1'($urandom);
            bus.mem_wdata     = 8'($urandom);
            bus.result_sel    = 2'($urandom);
            bus.select_c      = 1'($urandom);
            bus.select_z      = 1'($urandom);
            bus.write_c       = 1'($urandom);
            bus.write_z       = 1'($urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
